serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing in_a - in_b - bin one bit per clock, LSB first, with a registered borrow.
- Counterpart to the team's ripple-carry adder. It does the reverse arithmetic direction, and trades the adder's combinational ripple for one cycle per bit.
- Used in the lab datapath where area matters more than latency. It is started by a one-cycle start pulse and reports completion with a one-cycle done pulse.

---
 rtl/sub_pkg.sv | 13 +
 rtl/fullsubtractor.sv | 17 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell, the arithmetic counterpart of the fulladder
// cell: computes a - b - bin and the borrow into the next bit position.
module fullsubtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  // Difference bit and borrow-out for a single bit position
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes in_a - in_b - bin one bit per clock, LSB
// first, reusing a single full-subtractor cell and a registered borrow.
// The result, borrow-out and signed overflow appear together with a
// one-cycle done pulse and are held until the next operation completes.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  fullsubtractor u_cell (
    .diff (bit_d),
    .bout (bit_bout),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow)
  );

  // The new difference bit enters at the MSB of the result shifter, so after
  // WIDTH shifts the first (LSB) bit has reached position 0.
  assign res_cat  = {bit_d, res_sh};
  assign res_next = WIDTH'(res_cat >> 1);
  assign last_bit = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting and registered result update
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            borrow <= bin;
            cnt    <= '0;
            res_sh <= '0;
            a_msb  <= in_a[WIDTH-1];
            b_msb  <= in_b[WIDTH-1];
          end
        end
        RUN: begin
          borrow <= bit_bout;
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff <= res_next;
            bout <= bit_bout;
            ovf  <= (a_msb != b_msb) && (bit_d != a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int compared;
  int mismatched;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with a one-cycle start pulse; returns just after the
  // accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch cycles (sampled on the falling edge) until done, bounded; reports
  // latency, busy cycles, done in the following cycle and any diff change
  // while busy
  task automatic wait_done(output int lat, output int busy_cnt,
                           output logic done_after, output logic diff_moved);
    logic [W-1:0] prev;
    lat        = 0;
    busy_cnt   = 0;
    done_after = 1'b1;
    diff_moved = 1'b0;
    prev       = diff;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (diff !== prev) diff_moved = 1'b1;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      done_after = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    compared++;
    if (diff !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_diff got %h want 0", diff); end
    compared++;
    if (bout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bout got %b want 0", bout); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
  endtask

  // 9 - 3: signed -7 - 3 = -10 overflows four bits, unsigned has no borrow
  task automatic test_basic_timing();
    int lat, bc;
    logic da, dm;
    start_op(4'd9, 4'd3, 1'b0);
    wait_done(lat, bc, da, dm);
    compared++;
    if (lat != 5) begin mismatched++; $display("[TB] FAIL basic_latency got %0d want 5", lat); end
    compared++;
    if (bc != 4) begin mismatched++; $display("[TB] FAIL basic_busy_cycles got %0d want 4", bc); end
    compared++;
    if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_width got %b want 0", da); end
    compared++;
    if (dm !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_diff_stable got %b want 0", dm); end
    compared++;
    if (diff !== 4'd6) begin mismatched++; $display("[TB] FAIL basic_diff got %h want 6", diff); end
    compared++;
    if (bout !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_bout got %b want 0", bout); end
    compared++;
    if (ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_ovf got %b want 1", ovf); end
  endtask

  // Table of directed vectors with hand-computed results
  task automatic test_vectors();
    logic [W-1:0] va[3]  = '{4'd3, 4'd0, 4'h8};
    logic [W-1:0] vb[3]  = '{4'd9, 4'd0, 4'd1};
    logic         vi[3]  = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] ed[3]  = '{4'hA, 4'hF, 4'd7};
    logic         eb[3]  = '{1'b1, 1'b1, 1'b0};
    logic         eo[3]  = '{1'b1, 1'b0, 1'b1};
    int lat, bc;
    logic da, dm;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], vi[i]);
      wait_done(lat, bc, da, dm);
      compared++;
      if (diff !== ed[i]) begin mismatched++; $display("[TB] FAIL vec%0d_diff got %h want %h", i, diff, ed[i]); end
      compared++;
      if (bout !== eb[i]) begin mismatched++; $display("[TB] FAIL vec%0d_bout got %b want %b", i, bout, eb[i]); end
      compared++;
      if (ovf !== eo[i]) begin mismatched++; $display("[TB] FAIL vec%0d_ovf got %b want %b", i, ovf, eo[i]); end
    end
  endtask

  // start held high and operands changed during RUN: only the captured
  // operands count, the start seen in DONE is dropped, the next op begins
  // one cycle later from IDLE with the new operands (7 - 2)
  task automatic test_back_to_back();
    int lat, bc;
    logic da, dm;
    @(negedge clk);
    in_a  = 4'd9;
    in_b  = 4'd3;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    in_a = 4'd7;
    in_b = 4'd2;
    wait_done(lat, bc, da, dm);
    compared++;
    if (lat != 5) begin mismatched++; $display("[TB] FAIL held_latency got %0d want 5", lat); end
    compared++;
    if (diff !== 4'd6) begin mismatched++; $display("[TB] FAIL held_diff got %h want 6", diff); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL held_idle_gap got busy=%b want 0", busy); end
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL held_restart got busy=%b want 1", busy); end
    start = 1'b0;
    wait_done(lat, bc, da, dm);
    compared++;
    if (lat != 4) begin mismatched++; $display("[TB] FAIL second_latency got %0d want 4", lat); end
    compared++;
    if (dm !== 1'b0) begin mismatched++; $display("[TB] FAIL second_diff_stable got %b want 0", dm); end
    compared++;
    if (diff !== 4'd5) begin mismatched++; $display("[TB] FAIL second_diff got %h want 5", diff); end
  endtask

  // Reset in the second RUN cycle aborts without a done pulse
  task automatic test_reset_mid_run();
    int lat, bc;
    logic da, dm;
    logic saw_done;
    start_op(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    compared++;
    if (diff !== 4'h0) begin mismatched++; $display("[TB] FAIL abort_diff got %h want 0", diff); end
    compared++;
    if (bout !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_bout got %b want 0", bout); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ovf got %b want 0", ovf); end
    saw_done = done;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    compared++;
    if (saw_done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_no_done got %b want 0", saw_done); end
    start_op(4'd5, 4'd2, 1'b0);
    wait_done(lat, bc, da, dm);
    compared++;
    if (lat != 5) begin mismatched++; $display("[TB] FAIL after_abort_latency got %0d want 5", lat); end
    compared++;
    if (diff !== 4'd3) begin mismatched++; $display("[TB] FAIL after_abort_diff got %h want 3", diff); end
    compared++;
    if (bout !== 1'b0) begin mismatched++; $display("[TB] FAIL after_abort_bout got %b want 0", bout); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL after_abort_ovf got %b want 0", ovf); end
  endtask

  // Test sequence
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    in_a       = '0;
    in_b       = '0;
    bin        = 1'b0;
    test_reset();
    test_basic_timing();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
